// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier; product and one-cycle done appear WIDTH+2 cycles after start.
// No backpressure: start is accepted only while idle, and a start seen during RUN is dropped, not queued.
module booth_mult_seq #(
   parameter int WIDTH = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_sgn,
   input  logic [WIDTH-1:0]   i_multiplicand,
   input  logic [WIDTH-1:0]   i_multiplier,
   output logic               o_busy,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_product
);

   localparam int QW = WIDTH + 1;
   localparam int AW = WIDTH + 2;
   localparam int CW = $clog2(WIDTH + 2);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]    r_state;
   logic [AW-1:0] r_m;
   logic [AW-1:0] r_a;
   logic [QW-1:0] r_q;
   logic          r_qm1;
   logic [CW-1:0] r_cnt;

   logic [AW-1:0] w_m_ext;
   logic [QW-1:0] w_q_ext;
   logic [AW-1:0] w_sum;
   logic [AW-1:0] w_a_sh;
   logic [QW-1:0] w_q_sh;
   logic          w_last;

   // Operands are widened by one bit so unsigned values survive the signed Booth recoding.
   assign w_m_ext = {{2{i_sgn & i_multiplicand[WIDTH-1]}}, i_multiplicand};
   assign w_q_ext = {i_sgn & i_multiplier[WIDTH-1], i_multiplier};

   always_comb begin
      w_sum = r_a;
      case ({r_q[0], r_qm1})
         2'b10:   w_sum = r_a - r_m;
         2'b01:   w_sum = r_a + r_m;
         default: w_sum = r_a;
      endcase
   end

   assign w_a_sh = {w_sum[AW-1], w_sum[AW-1:1]};
   assign w_q_sh = {w_sum[0], r_q[QW-1:1]};
   assign w_last = (r_cnt == CW'(1));
   assign o_busy = r_state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_m       <= '0;
         r_a       <= '0;
         r_q       <= '0;
         r_qm1     <= 1'b0;
         r_cnt     <= '0;
         o_done    <= 1'b0;
         o_product <= '0;
      end else begin
         o_done <= 1'b0;
         if (r_state == S_IDLE) begin
            if (i_start) begin
               r_m     <= w_m_ext;
               r_q     <= w_q_ext;
               r_a     <= '0;
               r_qm1   <= 1'b0;
               r_cnt   <= CW'(WIDTH + 1);
               r_state <= S_RUN;
            end
         end else begin
            r_a   <= w_a_sh;
            r_q   <= w_q_sh;
            r_qm1 <= r_q[0];
            r_cnt <= r_cnt - CW'(1);
            // Low 2*WIDTH bits of the final shifted {A,Q} are exact in both modes.
            if (w_last) begin
               o_product <= {w_a_sh[WIDTH-2:0], w_q_sh};
               o_done    <= 1'b1;
               r_state   <= S_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: WIDTH=16 and WIDTH=4 instances against an arithmetic product model.
module tb_booth_mult_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start16 = 1'b0;
   logic        start4 = 1'b0;
   logic        sgn = 1'b0;
   logic [15:0] mcand = '0;
   logic [15:0] mplier = '0;
   logic        busy16, done16, busy4, done4;
   logic [31:0] prod16;
   logic [7:0]  prod4;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   booth_mult_seq #(.WIDTH(16)) dut16 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start16), .i_sgn(sgn),
      .i_multiplicand(mcand), .i_multiplier(mplier),
      .o_busy(busy16), .o_done(done16), .o_product(prod16)
   );

   booth_mult_seq #(.WIDTH(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_sgn(sgn),
      .i_multiplicand(mcand[3:0]), .i_multiplier(mplier[3:0]),
      .o_busy(busy4), .o_done(done4), .o_product(prod4)
   );

   typedef struct {
      int          w;
      bit          s;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] refmul(input int w, input bit s, input logic [15:0] a,
                                          input logic [15:0] b);
      longint x, y, p, mask;
      mask = (longint'(1) << w) - 1;
      x = longint'(a) & mask;
      y = longint'(b) & mask;
      if (s && x[w-1]) x = x - (longint'(1) << w);
      if (s && y[w-1]) y = y - (longint'(1) << w);
      p = (x * y) & ((longint'(1) << (2 * w)) - 1);
      return p[31:0];
   endfunction

   // Issues one operation from mid-cycle (cycle 0) and returns at the negedge of the done cycle.
   task automatic op(input int w, input bit s, input logic [15:0] a, input logic [15:0] b,
                     input bit scr, output logic [31:0] p, output int lat);
      bit bad_win;
      bit bsy, dn;
      bad_win = 1'b0;
      lat = -1;
      p = '0;
      sgn = s; mcand = a; mplier = b;
      if (w == 16) start16 = 1'b1; else start4 = 1'b1;
      for (int c = 1; c <= w + 12; c++) begin
         @(posedge clk); #1;
         start16 = 1'b0; start4 = 1'b0;
         if (scr && c <= w + 1) begin
            sgn = 1'($urandom); mcand = 16'($urandom); mplier = 16'($urandom);
            if (w == 16) start16 = 1'($urandom); else start4 = 1'($urandom);
         end
         @(negedge clk);
         bsy = (w == 16) ? busy16 : busy4;
         dn  = (w == 16) ? done16 : done4;
         if (bsy != (c <= w + 1)) bad_win = 1'b1;
         if (dn) begin
            lat = c;
            p = (w == 16) ? prod16 : {24'b0, prod4};
            break;
         end
      end
      start16 = 1'b0; start4 = 1'b0;
      check("busy_window", 32'(bad_win), 32'd0);
   endtask

   task automatic run_check(input string name, input int w, input bit s, input logic [15:0] a,
                            input logic [15:0] b, input bit scr, input logic [31:0] exp);
      logic [31:0] p;
      int lat;
      op(w, s, a, b, scr, p, lat);
      check({name, "_product"}, p, exp);
      check({name, "_latency"}, 32'(lat), 32'(w + 2));
   endtask

   initial begin
      int done_c[$];
      int seen;
      vecs[0]  = '{16, 1'b1, 16'h0003, 16'hFFFB, 32'hFFFF_FFF1};
      vecs[1]  = '{16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
      vecs[2]  = '{16, 1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001};
      vecs[3]  = '{16, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000};
      vecs[4]  = '{16, 1'b0, 16'h8000, 16'h8000, 32'h4000_0000};
      vecs[5]  = '{16, 1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000};
      vecs[6]  = '{16, 1'b0, 16'hFFFF, 16'h0001, 32'h0000_FFFF};
      vecs[7]  = '{16, 1'b1, 16'h0000, 16'h8000, 32'h0000_0000};
      vecs[8]  = '{4,  1'b1, 16'h0008, 16'h0007, 32'h0000_00C8};
      vecs[9]  = '{4,  1'b0, 16'h000F, 16'h000F, 32'h0000_00E1};
      vecs[10] = '{4,  1'b1, 16'h0008, 16'h0008, 32'h0000_0040};
      vecs[11] = '{4,  1'b1, 16'h0007, 16'h0007, 32'h0000_0031};

      repeat (2) @(negedge clk);
      check("rst_busy16", 32'(busy16), 32'd0);
      check("rst_done16", 32'(done16), 32'd0);
      check("rst_prod16", prod16, 32'd0);
      check("rst_busy4", 32'(busy4), 32'd0);
      check("rst_done4", 32'(done4), 32'd0);
      check("rst_prod4", 32'(prod4), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Consecutive calls issue start in the previous done cycle (back-to-back).
      foreach (vecs[i])
         run_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].b, 1'b0,
                   vecs[i].exp);

      @(negedge clk);
      sgn = 1'b0; mcand = 16'd7; mplier = 16'd9; start16 = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (c == 40) start16 = 1'b0;
         @(negedge clk);
         if (done16) begin
            done_c.push_back(c);
            check("hold_product", prod16, 32'h0000_003F);
         end
      end
      check("hold_count", 32'(done_c.size()), 32'd2);
      if (done_c.size() == 2) begin
         check("hold_done0", 32'(done_c[0]), 32'd18);
         check("hold_done1", 32'(done_c[1]), 32'd36);
      end
      seen = 0;
      for (int c = 0; c < 30 && seen == 0; c++) begin
         @(negedge clk);
         if (done16) seen = 1;
      end
      check("hold_drain", 32'(seen), 32'd1);
      @(negedge clk);

      for (int i = 0; i < 24; i++) begin
         int          w;
         bit          s;
         logic [15:0] a, b;
         w = (i % 4 == 3) ? 4 : 16;
         s = 1'($urandom);
         a = 16'($urandom);
         b = 16'($urandom);
         run_check($sformatf("rnd%0d", i), w, s, a, b, 1'(i % 2), refmul(w, s, a, b));
      end

      run_check("pre_rst", 16, 1'b1, 16'h1234, 16'h0005, 1'b0, 32'h0000_5B04);
      @(negedge clk);
      sgn = 1'b1; mcand = 16'h4321; mplier = 16'h00FF; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_busy_before", 32'(busy16), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy16), 32'd0);
      check("mid_rst_done", 32'(done16), 32'd0);
      check("mid_rst_prod", prod16, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (done16 || busy16) seen++;
      end
      check("mid_rst_no_done", 32'(seen), 32'd0);
      run_check("after_rst", 16, 1'b1, 16'd100, 16'hFFFE, 1'b0, 32'hFFFF_FF38);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier with an integrated controller, start/busy/done handshake and selectable signed/unsigned operand mode. It replaces the earlier fixed 16-bit datapath-only Booth block, which needed an external controller. It sits as a multi-cycle arithmetic unit beside the datapath and returns a full-width `2*WIDTH` product with fixed latency.

## Interface
- `WIDTH`, default 16: operand width in bits; legal range is 2 or more.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous reset, active-low.
- `start`  input  1  request a multiply; sampled only while idle.
- `sgn`  input  1  operand mode, sampled with `start`: 1 = two's-complement, 0 = unsigned.
- `multiplicand`  input  WIDTH  M operand, sampled with `start`.
- `multiplier`  input  WIDTH  Q operand, sampled with `start`.
- `busy`  output  1  high while an operation is in progress.
- `done`  output  1  one-cycle pulse when `product` is updated.
- `product`  output  2*WIDTH  result register; holds its value until the next completion.

## Operation
- FSM has two states, IDLE and RUN. Reset state is IDLE. Reset values: `busy`=0, `done`=0, `product`=0, all internal registers 0.
- IDLE with `start`=1, at that edge:
  - Extend both operands to WIDTH+1 bits: sign-extend if `sgn`=1, zero-extend if `sgn`=0.
  - Load M ← extended multiplicand, Q ← extended multiplier, accumulator A ← 0, q₋₁ ← 0, iteration count ← WIDTH+1.
  - Go to RUN.
- Operands are latched at acceptance. Input changes after acceptance have no effect.
- RUN performs one iteration per edge:
  - Select on {Q[0], q₋₁}: 10 → A ← A − M; 01 → A ← A + M; 00 or 11 → A unchanged.
  - Then arithmetic-shift {A, Q, q₋₁} right by one.
  - Decrement the count.
- A is WIDTH+2 bits wide, so no intermediate overflow is possible for any operand pair.
- On the edge of the final iteration (count 1 → 0):
  - `product` ← low 2*WIDTH bits of the shifted {A, Q}.
  - `done` ← 1 for one cycle.
  - FSM → IDLE.
- The result is the exact product for all operand values in both modes, including most-negative × most-negative in signed mode.
- `start` while in RUN is ignored. It is not queued.
- `start` during the `done` cycle is accepted, because the FSM is already IDLE. This allows back-to-back operations.
- `rst_n` low at any time, including mid-operation, immediately clears all state and outputs. The aborted operation produces no `done`.

## Timing
- `start` sampled high at the edge ending cycle 0:
  - `busy`=1 in cycles 1 through WIDTH+1.
  - `done`=1 and the new `product` are visible in cycle WIDTH+2.
- Latency is WIDTH+2 cycles from the `start` cycle to `done`, independent of operand values and mode.
- Minimum issue interval is WIDTH+2 cycles, using `start` in each `done` cycle.
- `busy` and `done` are never high together. `done` is never high for two consecutive cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- WIDTH=16, signed, 3 × −5 (0x0003, 0xFFFB), `start` in cycle 0 → `done` only in cycle 18, `product`=0xFFFFFFF1; `busy` high in cycles 1–17.
- WIDTH=16, 0xFFFF × 0xFFFF in unsigned mode → 0xFFFE0001; same operands in signed mode → 0x00000001. Also signed 0x8000 × 0x8000 → 0x40000000.
- WIDTH=16, hold `start` high for 40 cycles with fixed operands 7 × 9 → exactly two completions, in cycles 18 and 36, each with `product`=0x0000003F. `start` pulses inside RUN cause no extra `done`.
- WIDTH=16, change operands every cycle while `busy` → result matches the operands sampled at acceptance.
- WIDTH=16, assert `rst_n` low in cycle 6 of an operation → `busy`, `done` and `product` read 0 within that cycle and no `done` follows. A new 100 × −2 then returns 0xFFFFFF38.
- WIDTH=4 instance: signed −8 × 7 → 8'hC8, `done` in cycle 6; unsigned 15 × 15 → 8'hE1; signed −8 × −8 → 8'h40.
